// File: rtl/proc_instr_receiver.sv
`default_nettype none
// ============================================================================
// Module   : proc_instr_receiver
// Brief    : Processor-side end of the issuer-to-SIMD command interface.
//            Collects LD(addr_0), LD(addr_1), INFO(count, op, wr_addr),
//            acknowledges each word, streams `count` element operations to
//            the local datapath (with stall), then holds finish until acked.
// Options  : PROC_RX_PROTO_CHECK_EN - adds o_proto_err; unexpected opcodes in
//            the GET states abort the command, and a stray finish ack flags
//            an error.
// Revision : 1.0 - initial release
// ============================================================================
module proc_instr_receiver #(
  parameter int ADDR_W   = 16,
  parameter int COUNT_W  = 8,
  parameter int OP_W     = 4,
  parameter int OPC_W    = 2,
  parameter int OPC_LD   = 1,
  parameter int OPC_INFO = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_rstn,
  input  logic                                   i_en,
  input  logic [OPC_W+COUNT_W+OP_W+ADDR_W-1:0]   i_instr,
  output logic                                   o_ack,
  output logic                                   o_busy,
  output logic                                   o_finish,
  input  logic                                   i_finish_ack,
  output logic [OP_W-1:0]                        o_op,
  output logic [ADDR_W-1:0]                      o_rd_addr_a,
  output logic [ADDR_W-1:0]                      o_rd_addr_b,
  output logic [ADDR_W-1:0]                      o_wr_addr,
  output logic                                   o_elem_valid,
`ifdef PROC_RX_PROTO_CHECK_EN
  output logic                                   o_proto_err,
`endif
  input  logic                                   i_stall
);

  localparam int                INSTR_W    = OPC_W + COUNT_W + OP_W + ADDR_W;
  localparam logic [OPC_W-1:0]  C_OPC_NOP  = '0;
  localparam logic [OPC_W-1:0]  C_OPC_LD   = OPC_W'(OPC_LD);
  localparam logic [OPC_W-1:0]  C_OPC_INFO = OPC_W'(OPC_INFO);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_LD1  = 3'd1,
    S_GET_LD2  = 3'd2,
    S_GET_INFO = 3'd3,
    S_EXEC     = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [ADDR_W-1:0]    r_addr0;
  logic [ADDR_W-1:0]    r_addr1;
  logic [ADDR_W-1:0]    r_wr;
  logic [COUNT_W-1:0]   r_count;
  logic [OP_W-1:0]      r_op;
  logic [COUNT_W-1:0]   r_idx;
  logic                 r_ack;
  logic                 r_finish;

  logic                 w_accept;
  logic                 w_last;

  // Instruction word fields: {opcode, count, op, addr}
  logic [OPC_W-1:0]     w_opc;
  logic [COUNT_W-1:0]   w_count;
  logic [OP_W-1:0]      w_op;
  logic [ADDR_W-1:0]    w_addr;

  assign w_opc   = i_instr[INSTR_W-1 -: OPC_W];
  assign w_count = i_instr[ADDR_W+OP_W +: COUNT_W];
  assign w_op    = i_instr[ADDR_W +: OP_W];
  assign w_addr  = i_instr[ADDR_W-1:0];

  // Last element is the one whose index equals count-1.
  assign w_last  = (r_idx == (r_count - COUNT_W'(1)));

`ifdef PROC_RX_PROTO_CHECK_EN
  logic w_bad_opc;
  logic w_stray_ack;
  logic r_proto_err;

  // Any non-NOP word that is not the one this GET state is waiting for.
  assign w_bad_opc =
      (((r_state == S_GET_LD1) || (r_state == S_GET_LD2)) &&
       (w_opc != C_OPC_NOP) && (w_opc != C_OPC_LD)) ||
      ((r_state == S_GET_INFO) &&
       (w_opc != C_OPC_NOP) && (w_opc != C_OPC_INFO));
  assign w_stray_ack = i_finish_ack && (r_state != S_FINISH);
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode and word-accept strobe.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en) w_next = S_GET_LD1;
      end
      S_GET_LD1: begin
        if (w_opc == C_OPC_LD) begin
          w_accept = 1'b1;
          w_next   = S_GET_LD2;
        end
      end
      S_GET_LD2: begin
        if (w_opc == C_OPC_LD) begin
          w_accept = 1'b1;
          w_next   = S_GET_INFO;
        end
      end
      S_GET_INFO: begin
        if (w_opc == C_OPC_INFO) begin
          w_accept = 1'b1;
          w_next   = (w_count == '0) ? S_FINISH : S_EXEC;
        end
      end
      S_EXEC: begin
        if (!i_stall && w_last) w_next = S_FINISH;
      end
      S_FINISH: begin
        // Only an ack of a visible finish closes the command; i_en is ignored.
        if (r_finish && i_finish_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
`ifdef PROC_RX_PROTO_CHECK_EN
    if (w_bad_opc) w_next = S_IDLE;
`endif
  end

  // Field latches, element index, ack pulse and finish flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_wr     <= '0;
      r_count  <= '0;
      r_op     <= '0;
      r_idx    <= '0;
      r_ack    <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_ack    <= w_accept;
      // Finish becomes visible one cycle into FINISH and drops with the ack.
      r_finish <= (r_state == S_FINISH) && !(r_finish && i_finish_ack);
      if (w_accept) begin
        case (r_state)
          S_GET_LD1: r_addr0 <= w_addr;
          S_GET_LD2: r_addr1 <= w_addr;
          S_GET_INFO: begin
            r_count <= w_count;
            r_op    <= w_op;
            r_wr    <= w_addr;
            r_idx   <= '0;
          end
          default: ;
        endcase
      end
      if ((r_state == S_EXEC) && !i_stall && !w_last) begin
        r_idx <= r_idx + COUNT_W'(1);
      end
    end
  end

`ifdef PROC_RX_PROTO_CHECK_EN
  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                        r_proto_err <= 1'b0;
    else if (w_bad_opc || w_stray_ack)  r_proto_err <= 1'b1;
  end

  assign o_proto_err = r_proto_err;
`endif

  assign o_ack        = r_ack;
  assign o_busy       = (r_state != S_IDLE);
  assign o_finish     = r_finish;
  assign o_elem_valid = (r_state == S_EXEC);
  assign o_op         = r_op;
  assign o_rd_addr_a  = r_addr0 + ADDR_W'(r_idx);
  assign o_rd_addr_b  = r_addr1 + ADDR_W'(r_idx);
  assign o_wr_addr    = r_wr    + ADDR_W'(r_idx);

endmodule
`default_nettype wire
